mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester lane and of the output.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-lane request/valid; bit i belongs to requester i.
REQ-005 last  input  4  per-lane end-of-burst flag; sampled only when Configuration REQ-027 is enabled.
REQ-006 din  input  4*WIDTH  lane data; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-007 dout_ready  input  1  downstream accepts dout this cycle.
REQ-008 gnt  output  4  one-hot grant; all-zero when no lane is granted.
REQ-009 sel  output  2  encoded select of the granted lane; sel[1] drives s1 and sel[0] drives s2 of the 4:1 mux (00=a/lane0, 01=b/lane1, 10=c/lane2, 11=d/lane3).
REQ-010 dout  output  WIDTH  data of the granted lane, selected combinationally by sel.
REQ-011 dout_valid  output  1  high when a transfer is offered downstream.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT, plus a 2-bit round-robin pointer ptr holding the last granted lane.
REQ-013 IDLE: gnt=0 and dout_valid=0; if req!=0, next state GRANT, with gnt/sel set to the first lane with req high, searching ptr+1, ptr+2, ptr+3, ptr (modulo 4).
REQ-014 Arbitration latency SHALL be one cycle: req rising in cycle n while IDLE yields gnt in cycle n+1.
REQ-015 GRANT: dout_valid = req[sel], combinationally; dout = lane sel of din.
REQ-016 A transfer occurs in a cycle when dout_valid and dout_ready are both high.
REQ-017 On a releasing transfer, ptr SHALL load sel; if any other req bit is high, the next lane in round-robin order from the new ptr is granted at the next edge (back-to-back, no IDLE bubble); otherwise next state IDLE.
REQ-018 A lone requester still requesting after its transfer SHALL be re-granted at the next edge (wrap-around to itself).
REQ-019 If req[sel] drops in GRANT without a transfer, the grant SHALL be released: ptr unchanged, next state IDLE.
REQ-020 dout_ready with dout_valid low SHALL have no effect; dout_valid SHALL never depend on dout_ready.
REQ-021 gnt SHALL change only on a clock edge and SHALL never be high on more than one lane at a time.
REQ-022 Requests arriving on other lanes while a grant is held SHALL wait; no requester is starved longer than three other grants.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, gnt=4'b0000, sel=2'b00, dout_valid=0 and ptr=2'b11, so lane 0 has first priority.
REQ-024 rst asserted mid-transfer or mid-burst SHALL abort the grant with no further transfer; arbitration restarts from the first clock edge after rst deasserts.
REQ-025 dout SHALL show lane 0 data during reset and is don't-care whenever dout_valid=0.

Configuration
REQ-026 Macro MUX_ARB_BURST_EN SHALL select burst mode.
REQ-027 Defined: a transfer releases the grant only if last[sel]=1; other transfers keep the grant with ptr unchanged. REQ-019 still applies, so dropping req mid-burst releases.
REQ-028 Undefined: every transfer releases the grant (single-beat mode), and the last input SHALL be ignored.

Verification
REQ-029 Reset then req=0001, dout_ready=1 -> gnt=0001 and sel=00 one cycle later; dout=lane0 data with dout_valid=1.
REQ-030 req=1111 held, dout_ready=1, single-beat -> grant order lane 0,1,2,3,0 on consecutive cycles with no idle bubble.
REQ-031 req=0100 granted, dout_ready=0 for 3 cycles -> gnt stays 0100 and dout_valid stays 1; dout_ready=1 -> one transfer, then IDLE.
REQ-032 Granted lane 2 drops req before ready -> next cycle state IDLE with gnt=0000; then req=1100 -> lane 2 granted, since ptr was not updated.
REQ-033 MUX_ARB_BURST_EN defined, req=0011, lane 0 burst of 3 with last on beat 3 -> lane 0 holds grant for 3 transfers, then lane 1 is granted; undefined -> grants alternate 0,1,0.
REQ-034 rst pulsed while lane 3 is granted with dout_valid=1 -> gnt=0000 and dout_valid=0 asynchronously; after release with req=1001, lane 0 is granted first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Four-lane round-robin arbiter that drives a 4:1 data mux. A two-state FSM
//   (IDLE/GRANT) holds one grant at a time. A 2-bit pointer records the last
//   lane that completed a releasing transfer. The search for the next lane
//   starts one past that pointer.
//
// Handshake: the granted lane's req acts as its valid. dout_valid_o = req[sel]
//   while in GRANT. A transfer happens on a rising edge where dout_valid_o and
//   dout_ready_i are both high. dout_valid_o never looks at dout_ready_i.
//
// Configuration macro: MUX_ARB_BURST_EN
//   undefined : every transfer releases the grant (single-beat); last_i ignored
//   defined   : a transfer releases only when last_i[sel] is high
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_i[3:0]   per-lane request/valid
//   last_i[3:0]  per-lane end-of-burst flag (burst mode only)
//   din_i        lane data, lane i at [i*WIDTH +: WIDTH]
//   dout_ready_i downstream ready
//   gnt_o[3:0]   one-hot grant, zero when idle
//   sel_o[1:0]   encoded mux select (sel[1]=s1, sel[0]=s2)
//   dout_o       data of lane sel_o
//   dout_valid_o transfer offered downstream
//   dbg_state_o  FSM state (0=IDLE, 1=GRANT)
module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_i,
  input  logic [3:0]         last_i,
  input  logic [4*WIDTH-1:0] din_i,
  input  logic               dout_ready_i,
  output logic [3:0]         gnt_o,
  output logic [1:0]         sel_o,
  output logic [WIDTH-1:0]   dout_o,
  output logic               dout_valid_o,
  output logic               dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       xfer;
  logic       release_grant;

  // First requesting lane in the order p+1, p+2, p+3, p. Looking at p last
  // lets a lone requester win again.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign dout_valid_o = (state_q == GRANT) && req_i[sel_q];
  assign xfer         = dout_valid_o && dout_ready_i;

`ifdef MUX_ARB_BURST_EN
  assign release_grant = xfer && last_i[sel_q];
`else
  logic unused_last;
  assign unused_last   = ^last_i;
  assign release_grant = xfer;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          sel_d   = rr_pick(req_i, ptr_q);
        end
      end
      GRANT: begin
        if (!req_i[sel_q]) begin
          // Requester withdrew before a transfer: drop the grant and leave
          // the pointer where it was.
          state_d = IDLE;
        end else if (release_grant) begin
          // req_i[sel_q] is high here, so a successor always exists. Other
          // lanes win first, and the current lane wins only if it is alone.
          ptr_d = sel_q;
          sel_d = rr_pick(req_i, sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grant comes straight from registers, so it only moves on a clock edge or
  // on reset.
  assign gnt_o       = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
  assign sel_o       = sel_q;
  assign dbg_state_o = state_q;

  always_comb begin
    dout_o = din_i[0 +: WIDTH];
    case (sel_q)
      2'd0: dout_o = din_i[0       +: WIDTH];
      2'd1: dout_o = din_i[WIDTH   +: WIDTH];
      2'd2: dout_o = din_i[2*WIDTH +: WIDTH];
      2'd3: dout_o = din_i[3*WIDTH +: WIDTH];
      default: dout_o = din_i[0 +: WIDTH];
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter. Inputs change 1 time unit after a rising
// edge. Outputs are sampled 1 time unit after that, which keeps both well
// clear of the active edge.
module tb_mux_rr_arbiter;
  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [3:0]         last;
  logic [4*WIDTH-1:0] din;
  logic               dout_ready;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .last_i       (last),
    .din_i        (din),
    .dout_ready_i (dout_ready),
    .gnt_o        (gnt),
    .sel_o        (sel),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    last = 4'b0000;
    dout_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Check the grant and data state of a granted lane.
  task automatic check_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_sel,
                             input logic exp_valid);
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    check({tag, "_valid"}, 32'(dout_valid), 32'(exp_valid));
    check({tag, "_dout"}, 32'(dout), 32'(8'hA0 + 8'(exp_sel)));
  endtask

  logic [3:0] exp_seq[5];

  initial begin
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst = 1'b1;
    req = 4'b0000;
    last = 4'b0000;
    dout_ready = 1'b0;
    #2;
    // reset state, before any clock edge
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_dout", 32'(dout), 32'hA0);
    check("rst_state", 32'(dbg_state), 32'h0);
    step();
    step();
    rst = 1'b0;

    // single requester lane 0, one-cycle latency
    req = 4'b0001; dout_ready = 1'b1; settle();
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_valid", 32'(dout_valid), 32'h0);
    step();
    check_grant("t1_g0", 4'b0001, 2'd0, 1'b1);
    check("t1_state", 32'(dbg_state), 32'h1);
    step();
    // lone requester re-granted after its transfer
    req = 4'b0000; settle();
    check_grant("t1_regrant", 4'b0001, 2'd0, 1'b0);
    step();
    check("t1_released_gnt", 32'(gnt), 32'h0);
    check("t1_released_state", 32'(dbg_state), 32'h0);

    // all four requesting, single-beat rotation after reset
    do_reset();
    req = 4'b1111; dout_ready = 1'b1;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_rot%0d", i), 32'(gnt), 32'(exp_seq[i]));
      check($sformatf("t2_valid%0d", i), 32'(dout_valid), 32'h1);
    end
    req = 4'b0000; step();
    check("t2_idle", 32'(gnt), 32'h0);

    // lane 2 held off by backpressure, then one transfer
    do_reset();
    req = 4'b0100; dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant($sformatf("t3_wait%0d", i), 4'b0100, 2'd2, 1'b1);
    end
    dout_ready = 1'b1; settle();
    check("t3_xfer_valid", 32'(dout_valid), 32'h1);
    step();
    req = 4'b0000; settle();
    check("t3_after_valid", 32'(dout_valid), 32'h0);
    step();
    check("t3_idle_gnt", 32'(gnt), 32'h0);
    check("t3_idle_state", 32'(dbg_state), 32'h0);

    // lane 2 withdraws before ready; pointer must not move
    do_reset();
    req = 4'b0100; dout_ready = 1'b0;
    step();
    check("t4_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000; settle();
    check("t4_drop_valid", 32'(dout_valid), 32'h0);
    dout_ready = 1'b1; settle();
    check("t4_ready_novalid", 32'(dout_valid), 32'h0);
    dout_ready = 1'b0;
    step();
    check("t4_idle_gnt", 32'(gnt), 32'h0);
    req = 4'b1100;
    step();
    check_grant("t4_regrant2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000; step();

    // two requesters, burst vs single-beat
    do_reset();
    req = 4'b0011; dout_ready = 1'b1; last = 4'b0000;
`ifdef MUX_ARB_BURST_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      last = (i == 2) ? 4'b0001 : 4'b0000;
      check($sformatf("t5_seq%0d", i), 32'(gnt), 32'(exp_seq[i]));
    end
    req = 4'b0000; last = 4'b0000; step();

    // asynchronous reset while lane 3 is granted
    do_reset();
    req = 4'b1000; dout_ready = 1'b0;
    step();
    check_grant("t6_g3", 4'b1000, 2'd3, 1'b1);
    rst = 1'b1; settle();
    check("t6_async_gnt", 32'(gnt), 32'h0);
    check("t6_async_valid", 32'(dout_valid), 32'h0);
    check("t6_async_sel", 32'(sel), 32'h0);
    check("t6_async_dout", 32'(dout), 32'hA0);
    req = 4'b1001; dout_ready = 1'b1;
    step();
    rst = 1'b0; settle();
    check("t6_post_rst_gnt", 32'(gnt), 32'h0);
    step();
    check_grant("t6_first0", 4'b0001, 2'd0, 1'b1);
    step();
    check("t6_then3", 32'(gnt), 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
